msx_mapper_gen2: RTL
====================

# msx_mapper_gen2

Second-generation MSX memory mapper controller for the console CPLD. It is synchronous to the Z80 clock and holds one segment register per 16 KB page on I/O ports FCh–FFh, with a parametrised segment width. It drives the RAM bank address for the current page and adds the capability the first mapper lacked: an M1 wait-state generator for slow ROM and flash devices. It sits beside the slot expander, and its RAMA output feeds the RAM/ROM bank mux for the mapper sub-slot.

## Interface
- BANK_BITS, 5, segment register width (2..8); 5 gives 512 KB.
- IO_BASE, 8'hFC, base I/O port; addrL[7:2] must equal IO_BASE[7:2].
- WAIT_CYCLES, 1, wait states inserted per M1 opcode fetch (0 disables, max 7).
- CLK  in  1  Z80 clock; all state on rising edge.
- RSTb  in  1  asynchronous, active-low reset.
- addrH  in  2  CPU A[15:14], page select.
- addrL  in  8  CPU A[7:0].
- data_in  in  8  CPU data bus input.
- IORQb, MREQb, RDb, WRb, M1b, RFSHb  in  1 each  Z80 bus strobes, active-low.
- RAMA  out  BANK_BITS  segment for the currently addressed page.
- DOUT  out  8  readback data.
- DOE  out  1  readback drive enable to the top-level data mux.
- WAITb  out  1  Z80 WAIT, active-low.

## Operation
- Selection: SEL = ~IORQb & M1b & (addrL[7:2] == IO_BASE[7:2]). Register index = addrL[1:0]. Port FCh is page 0 and FFh is page 3.
- Write: wr_q is the registered copy of (SEL & ~WRb). A write commits on the rising edge where SEL & ~WRb is 1 and wr_q is 0, which gives exactly one commit per strobe. Committed value: seg[addrL[1:0]] <= data_in[BANK_BITS-1:0]. Upper data bits are discarded.
- Read: DOE = SEL & ~RDb, combinational. DOUT = {(8-BANK_BITS){1'b1}, seg[addrL[1:0]]}. Unimplemented bits read as 1, per MSX convention.
- RAMA = seg[addrH], combinational from the registers.
- Interrupt-acknowledge cycles (IORQ with M1 low) never select the block.
- Refresh cycles (~RFSHb) never start a wait and never write.
- Wait FSM, with three states:
  - IDLE -> WAIT when MREQb falls (registered edge detect) with ~M1b & RFSHb & WAIT_CYCLES != 0. The counter loads WAIT_CYCLES-1.
  - WAIT: WAITb = 0. The counter decrements each clock. The FSM moves to HOLD when the counter is 0.
  - HOLD: WAITb = 1. The FSM returns to IDLE when MREQb is high, so there is one wait burst per fetch.
  - If MREQb rises while in WAIT, the FSM goes directly to IDLE and WAITb is released on that edge.
- Boundaries:
  - BANK_BITS = 8: DOUT has no padding.
  - A write to a page register while that page is addressed: RAMA changes after the commit edge. There is no glitch beyond the register update.
  - Back-to-back OUTs to the same port: the last one wins.

## Timing
- Reset values: seg[0..3] = 3, 2, 1, 0. RAMA = seg[addrH]. DOE = 0. DOUT = {pad, seg[addrL[1:0]]}. WAITb = 1. FSM = IDLE. wr_q = 0.
- Reset asserted mid-wait releases WAITb immediately, asynchronously.
- Write latency: the register updates on the first rising CLK at which WRb is sampled low with SEL. RAMA reflects the new value after that edge.
- Wait latency: WAITb goes low on the edge after the MREQb fall is detected. It stays low for exactly WAIT_CYCLES clocks.
- Read path: DOE and DOUT are combinational, with no clock latency.

## Structure
- Shared package msx_bus_pkg holds:
  - the IO_MAPPER_BASE (8'hFC) constant;
  - the reset segment constants;
  - the wait FSM state typedef (IDLE/WAIT/HOLD, 2-bit).
- Sub-module msx_wait_gen contains the wait FSM and counter, parametrised by WAIT_CYCLES. It is reusable for the VDP and slot-side wait paths.
- The top of the block contains the segment registers, write edge detect and readback mux.

## Test plan
- Reset check: release RSTb, then sweep addrH 0..3. RAMA must read 3, 2, 1, 0. IN from FCh–FFh returns E3h, E2h, E1h, E0h (BANK_BITS = 5).
- OUT FEh,0x9F with BANK_BITS = 5: seg[2] = 1Fh. IN FEh returns FFh. addrH = 2 gives RAMA = 1Fh.
- Hold WRb low for 4 clocks during OUT FDh,07h, changing data_in after the first edge: exactly one commit, with the value sampled on the first edge.
- M1 fetch with WAIT_CYCLES = 2: WAITb must be low for exactly 2 clocks, then high until the next fetch. A non-M1 read and a refresh cycle must produce no wait.
- Assert RSTb low during the WAIT state: WAITb must go to 1 immediately and seg must return to 3, 2, 1, 0.
- Interrupt acknowledge (~IORQb & ~M1b) with addrL = FCh: DOE must stay 0 and there must be no write.

Source files
------------

// File: rtl/msx_bus_pkg.sv
// Shared MSX bus definitions: mapper port base, segment reset values and wait FSM states.
// Imported by the mapper and by the reusable wait-state generator.
package msx_bus_pkg;

  localparam logic [7:0] IO_MAPPER_BASE = 8'hFC;

  // Power-on mapping puts segment 3 in page 0 down to segment 0 in page 3
  localparam logic [7:0] SEG_RST_P0 = 8'h03;
  localparam logic [7:0] SEG_RST_P1 = 8'h02;
  localparam logic [7:0] SEG_RST_P2 = 8'h01;
  localparam logic [7:0] SEG_RST_P3 = 8'h00;

  typedef enum logic [1:0] {
    WS_IDLE = 2'b00,
    WS_WAIT = 2'b01,
    WS_HOLD = 2'b10
  } wait_state_e;

  // Forces every bit at or above 'bits' to 1 so unimplemented segment bits read high
  function automatic logic [7:0] pad_readback(input logic [7:0] seg, input int unsigned bits);
    logic [7:0] mask;
    mask = 8'hFF << bits;
    return (seg & ~mask) | mask;
  endfunction

endpackage

// File: rtl/msx_wait_gen.sv
// Z80 M1 wait-state generator: inserts WAIT_CYCLES wait clocks once per opcode fetch.
// Reusable for any wait path that keys off an MREQ falling edge during M1.
module msx_wait_gen
  import msx_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_mreq_n,
  input  logic i_m1_n,
  input  logic i_rfsh_n,
  output logic o_wait_n
);

  localparam bit         WAIT_EN  = (WAIT_CYCLES != 0);
  localparam logic [2:0] CNT_LOAD = WAIT_EN ? 3'(WAIT_CYCLES - 1) : 3'd0;

  wait_state_e r_state;
  wait_state_e w_state_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_next;
  logic        r_mreq_q;
  logic        r_wait_n;
  logic        w_fetch_start;

  assign w_fetch_start = WAIT_EN & r_mreq_q & ~i_mreq_n & ~i_m1_n & i_rfsh_n;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      WS_IDLE: begin
        if (w_fetch_start) begin
          w_state_next = WS_WAIT;
          w_cnt_next   = CNT_LOAD;
        end else begin
          w_state_next = WS_IDLE;
        end
      end
      WS_WAIT: begin
        // An aborted fetch releases WAIT straight away rather than finishing the burst
        if (i_mreq_n) begin
          w_state_next = WS_IDLE;
        end else if (r_cnt == 3'd0) begin
          w_state_next = WS_HOLD;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      WS_HOLD: begin
        if (i_mreq_n) begin
          w_state_next = WS_IDLE;
        end else begin
          w_state_next = WS_HOLD;
        end
      end
      default: begin
        w_state_next = WS_IDLE;
        w_cnt_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= WS_IDLE;
      r_cnt    <= 3'd0;
      r_mreq_q <= 1'b1;
      r_wait_n <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_mreq_q <= i_mreq_n;
      r_wait_n <= (w_state_next != WS_WAIT);
    end
  end

  assign o_wait_n = r_wait_n;

endmodule

// File: rtl/msx_mapper_gen2.sv
// MSX memory mapper with four page segment registers on ports FCh-FFh, MSX-style
// readback padding and an M1 wait-state generator for slow ROM/flash.
module msx_mapper_gen2
  import msx_bus_pkg::*;
#(
  parameter int         BANK_BITS   = 5,
  parameter logic [7:0] IO_BASE     = IO_MAPPER_BASE,
  parameter int         WAIT_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic [1:0]           addrH,
  input  logic [7:0]           addrL,
  input  logic [7:0]           data_in,
  input  logic                 IORQb,
  input  logic                 MREQb,
  input  logic                 RDb,
  input  logic                 WRb,
  input  logic                 M1b,
  input  logic                 RFSHb,
  output logic [BANK_BITS-1:0] RAMA,
  output logic [7:0]           DOUT,
  output logic                 DOE,
  output logic                 WAITb
);

  logic [BANK_BITS-1:0] r_seg [4];
  logic                 r_wr_q;
  logic                 w_sel;
  logic                 w_wr;
  logic                 w_commit;
  logic [BANK_BITS-1:0] w_rd_seg;

  // M1 low with IORQ marks interrupt acknowledge, which must never hit the mapper
  assign w_sel    = ~IORQb & M1b & (addrL[7:2] == IO_BASE[7:2]);
  assign w_wr     = w_sel & ~WRb & RFSHb;
  assign w_commit = w_wr & ~r_wr_q;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_wr_q   <= 1'b0;
      r_seg[0] <= SEG_RST_P0[BANK_BITS-1:0];
      r_seg[1] <= SEG_RST_P1[BANK_BITS-1:0];
      r_seg[2] <= SEG_RST_P2[BANK_BITS-1:0];
      r_seg[3] <= SEG_RST_P3[BANK_BITS-1:0];
    end else begin
      r_wr_q <= w_wr;
      if (w_commit) begin
        r_seg[addrL[1:0]] <= data_in[BANK_BITS-1:0];
      end
    end
  end

  always_comb begin
    w_rd_seg = r_seg[addrL[1:0]];
    RAMA     = r_seg[addrH];
    DOE      = w_sel & ~RDb;
    DOUT     = pad_readback(8'(w_rd_seg), BANK_BITS);
  end

  generate
    if (BANK_BITS < 8) begin : g_unused_data
      logic w_unused_data;
      assign w_unused_data = ^data_in[7:BANK_BITS];
    end
  endgenerate

  msx_wait_gen #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_gen (
    .i_clk   (CLK),
    .i_rst_n (RSTb),
    .i_mreq_n(MREQb),
    .i_m1_n  (M1b),
    .i_rfsh_n(RFSHb),
    .o_wait_n(WAITb)
  );

endmodule
